// File: rtl/shift_add_mult4_pkg.sv
// Shared types and constants for the 4x4 shift-and-add multiplier.
package mult4_pkg;
  localparam int WIDTH     = 4;
  localparam int PROD_W    = 8;
  localparam int ITER_LAST = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/shift_add_mult4_if.sv
// Operand/product handshake bundle for shift_add_mult4.
interface shift_add_mult4_if;
  import mult4_pkg::*;

  logic              start_valid;
  logic              start_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              p_valid;
  logic              p_ready;
  logic [PROD_W-1:0] p;
  logic              busy;

  modport master (output start_valid, a, b, p_ready,
                  input  start_ready, p_valid, p, busy);
  modport slave  (input  start_valid, a, b, p_ready,
                  output start_ready, p_valid, p, busy);
endinterface

// File: rtl/shift_add_mult4_ripple.sv
// Existing 4-bit ripple-carry adder with bit-level ports.
module ripple (
  input  logic A3, A2, A1, A0,
  input  logic B3, B2, B1, B0,
  input  logic Cin,
  output logic S3, S2, S1, S0,
  output logic C4
);
  logic C1, C2, C3;

  assign S0 = A0 ^ B0 ^ Cin;
  assign C1 = (A0 & B0) | (Cin & (A0 ^ B0));
  assign S1 = A1 ^ B1 ^ C1;
  assign C2 = (A1 & B1) | (C1 & (A1 ^ B1));
  assign S2 = A2 ^ B2 ^ C2;
  assign C3 = (A2 & B2) | (C2 & (A2 ^ B2));
  assign S3 = A3 ^ B3 ^ C3;
  assign C4 = (A3 & B3) | (C3 & (A3 ^ B3));
endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier; one adder pass per cycle,
// valid/ready on both operand and product sides.
module shift_add_mult4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_add_mult4_if.slave  bus
);
  import mult4_pkg::*;

  if (WIDTH != 4) begin : g_bad_width
    $error("shift_add_mult4: WIDTH must be 4 (adder is fixed at 4 bits)");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("shift_add_mult4: CNT_W too narrow to hold WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] m, q, acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] addend, s;
  logic             c4;
  logic [WIDTH-1:0] acc_nxt, q_nxt;

  assign addend = q[0] ? m : '0;

  ripple u_add (
    .A3(acc[3]), .A2(acc[2]), .A1(acc[1]), .A0(acc[0]),
    .B3(addend[3]), .B2(addend[2]), .B1(addend[1]), .B0(addend[0]),
    .Cin(1'b0),
    .S3(s[3]), .S2(s[2]), .S1(s[1]), .S0(s[0]),
    .C4(c4)
  );

  // {C4,S,Q} shifted right by one: carry lands in ACC MSB, S[0] enters Q
  assign acc_nxt = {c4, s[WIDTH-1:1]};
  assign q_nxt   = {s[0], q[WIDTH-1:1]};

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m           <= '0;
      q           <= '0;
      acc         <= '0;
      cnt         <= '0;
      bus.p       <= '0;
      bus.p_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_valid) begin
          m     <= bus.a;
          q     <= bus.b;
          acc   <= '0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER_LAST)) begin
            bus.p       <= {acc_nxt, q_nxt};
            bus.p_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.p_ready) begin
          bus.p_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult4.sv
// Directed + exhaustive check of shift_add_mult4 against hand-computed products.
module tb_shift_add_mult4;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_cnt = 0;

  shift_add_mult4_if bus ();

  shift_add_mult4 #(.WIDTH(4), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.p_valid && bus.p_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic op(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp,
                    input int bp, input bit rnd);
    int  k, lat;
    bit  hs;
    k = 0;
    while (!bus.start_ready && k < 20) begin @(negedge clk); k++; end
    chk("ready", 16'(bus.start_ready), 16'd1);
    bus.a = ai; bus.b = bi; bus.start_valid = 1'b1;
    bus.p_ready = rnd ? 1'($urandom_range(0, 1)) : (bp == 0);
    @(negedge clk);
    bus.start_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.p_valid && lat < 12);
    chk($sformatf("lat %0d*%0d", ai, bi), 16'(lat), 16'd4);
    chk($sformatf("prod %0d*%0d", ai, bi), 16'(bus.p), 16'(exp));
    if (rnd) begin
      hs = 1'b0;
      for (int i = 0; i < 40 && !hs; i++) begin
        bus.p_ready = (i > 30) ? 1'b1 : 1'($urandom_range(0, 1));
        hs = bus.p_ready;
        @(negedge clk);
        if (!hs) chk("hold", 16'({bus.p_valid, bus.p}), 16'({1'b1, exp}));
      end
    end else begin
      repeat (bp) begin
        chk("bp_valid", 16'(bus.p_valid), 16'd1);
        chk("bp_p", 16'(bus.p), 16'(exp));
        chk("bp_ready", 16'(bus.start_ready), 16'd0);
        @(negedge clk);
      end
      bus.p_ready = 1'b1;
      @(negedge clk);
    end
    chk("post_valid", 16'(bus.p_valid), 16'd0);
    chk("post_ready", 16'(bus.start_ready), 16'd1);
  endtask

  initial begin
    int lat, hs_base;
    rst_n = 1'b0;
    bus.start_valid = 1'b0; bus.a = '0; bus.b = '0; bus.p_ready = 1'b0;
    #1;
    chk("rst_ready", 16'(bus.start_ready), 16'd1);
    chk("rst_busy",  16'(bus.busy), 16'd0);
    chk("rst_valid", 16'(bus.p_valid), 16'd0);
    chk("rst_p",     16'(bus.p), 16'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(4'd5,  4'd3,  8'h0F, 0, 1'b0);
    op(4'd15, 4'd15, 8'hE1, 0, 1'b0);
    op(4'd13, 4'd11, 8'h8F, 0, 1'b0);
    op(4'd0,  4'd9,  8'h00, 0, 1'b0);
    op(4'd7,  4'd6,  8'h2A, 5, 1'b0);

    // Pulse during CALC is ignored; a pair held through DONE waits for IDLE.
    bus.a = 4'd2; bus.b = 4'd3; bus.start_valid = 1'b1; bus.p_ready = 1'b0;
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    bus.a = 4'd9; bus.b = 4'd9; bus.start_valid = 1'b1;
    @(negedge clk);
    chk("calc_busy", 16'(bus.busy), 16'd1);
    chk("calc_ready", 16'(bus.start_ready), 16'd0);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.p_valid && lat < 12) begin @(negedge clk); lat++; end
    chk("ign_p", 16'(bus.p), 16'h06);
    bus.a = 4'd9; bus.b = 4'd9; bus.start_valid = 1'b1; bus.p_ready = 1'b1;
    @(negedge clk);
    chk("ovl_valid", 16'(bus.p_valid), 16'd0);
    chk("ovl_busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    chk("ovl_accept", 16'(bus.busy), 16'd1);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.p_valid && lat < 12) begin @(negedge clk); lat++; end
    chk("ovl_p", 16'(bus.p), 16'h51);
    @(negedge clk);
    chk("ovl_post", 16'(bus.p_valid), 16'd0);

    // Asynchronous reset two edges into CALC of 12*10.
    bus.a = 4'd12; bus.b = 4'd10; bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(bus.p_valid), 16'd0);
    chk("arst_p", 16'(bus.p), 16'h00);
    chk("arst_ready", 16'(bus.start_ready), 16'd1);
    chk("arst_busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", 16'(bus.start_ready), 16'd1);
    op(4'd3, 4'd4, 8'h0C, 0, 1'b0);

    hs_base = hs_cnt;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        op(4'(ai), 4'(bi), 8'(ai * bi), 0, 1'b1);
    chk("hs_count", 16'(hs_cnt - hs_base), 16'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
